// File: rtl/forwarding_hazard_unit.sv
// Operand-forwarding selects and load-use stall for the EX stage of the 5-stage RV64 pipeline.
// Tracks a shadow EX/MEM/WB pipeline of register indices and control bits in lock-step with the datapath.
module forwarding_hazard_unit #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush,
   output logic [1:0]        forward_a,
   output logic [1:0]        forward_b,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_read;
   } stage_t;

   localparam logic [1:0] SEL_REGFILE = 2'b00;
   localparam logic [1:0] SEL_WB      = 2'b01;
   localparam logic [1:0] SEL_MEM     = 2'b10;

   stage_t ex_q;
   stage_t mem_q;
   stage_t wb_q;
   stage_t ex_next;

   logic load_use;
   logic insert_bubble;

   // A producer only forwards when it is live, writes a register, and that register is not x0.
   function automatic logic produces(input stage_t s, input logic [REG_AW-1:0] src);
      return s.valid && s.reg_write && (s.rd != '0) && (s.rd == src);
   endfunction

   // Youngest producer (MEM) wins over the older one (WB); nothing forwards into an empty EX slot.
   function automatic logic [1:0] select_for(input stage_t ex, input stage_t mem, input stage_t wb,
                                              input logic [REG_AW-1:0] src);
      logic [1:0] sel;
      sel = SEL_REGFILE;
      if (ex.valid) begin
         if (produces(mem, src)) begin
            sel = SEL_MEM;
         end else if (produces(wb, src)) begin
            sel = SEL_WB;
         end
      end
      return sel;
   endfunction

   // A load in EX whose result the ID instruction needs cannot be forwarded in time; a taken
   // branch discards the ID instruction, so the stall is meaningless and suppressed.
   always_comb begin
      load_use = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                 ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
      stall    = load_use && !flush;
   end

   always_comb begin
      forward_a = select_for(ex_q, mem_q, wb_q, ex_q.rs1);
      forward_b = select_for(ex_q, mem_q, wb_q, ex_q.rs2);
   end

   // Bubbles are fully zeroed so a squashed slot never carries stale indices forward.
   always_comb begin
      insert_bubble = flush || stall || !id_valid;
      ex_next       = '0;
      if (!insert_bubble) begin
         ex_next.valid     = 1'b1;
         ex_next.rs1       = id_rs1;
         ex_next.rs2       = id_rs2;
         ex_next.rd        = id_rd;
         ex_next.reg_write = id_reg_write;
         ex_next.mem_read  = id_mem_read;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_next;
         mem_q <= ex_q;
         wb_q  <= mem_q;
      end
   end

   // Event counters wrap silently; they observe the pipeline but never feed back into it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall) begin
            stall_count <= stall_count + 1'b1;
         end
         if (flush) begin
            flush_count <= flush_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scoreboard bench for forwarding_hazard_unit: hand-derived expectations are queued as each ID
// instruction is driven and compared against the DUT on the following falling edge.
module tb_forwarding_hazard_unit;

   logic        clk;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rd;
   logic        id_reg_write;
   logic        id_mem_read;
   logic        flush;
   logic [1:0]  forward_a;
   logic [1:0]  forward_b;
   logic        stall;
   logic [31:0] stall_count;
   logic [31:0] flush_count;

   typedef struct {
      int          step;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        st;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t        expQueue[$];
   int          checkCount;
   int          errorCount;
   int          stepNum;
   logic [31:0] expStallCnt;
   logic [31:0] expFlushCnt;

   forwarding_hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rd       (id_rd),
      .id_reg_write(id_reg_write),
      .id_mem_read (id_mem_read),
      .flush       (flush),
      .forward_a   (forward_a),
      .forward_b   (forward_b),
      .stall       (stall),
      .stall_count (stall_count),
      .flush_count (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives one ID-stage slot just after the rising edge and queues what the DUT must show this cycle.
   task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic rw, input logic mr, input logic fl,
                                input logic [1:0] efa, input logic [1:0] efb, input logic est);
      exp_t e;
      @(posedge clk);
      #1;
      id_valid     = v;
      id_rs1       = rs1;
      id_rs2       = rs2;
      id_rd        = rd;
      id_reg_write = rw;
      id_mem_read  = mr;
      flush        = fl;
      stepNum++;
      e.step = stepNum;
      e.fa   = efa;
      e.fb   = efb;
      e.st   = est;
      e.sc   = expStallCnt;
      e.fc   = expFlushCnt;
      expQueue.push_back(e);
      expStallCnt = expStallCnt + {31'd0, est};
      expFlushCnt = expFlushCnt + {31'd0, fl};
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (expQueue.size() > 0) begin
         e = expQueue.pop_front();
         checkOutput($sformatf("s%0d_fwd_a", e.step), {30'd0, forward_a}, {30'd0, e.fa});
         checkOutput($sformatf("s%0d_fwd_b", e.step), {30'd0, forward_b}, {30'd0, e.fb});
         checkOutput($sformatf("s%0d_stall", e.step), {31'd0, stall}, {31'd0, e.st});
         checkOutput($sformatf("s%0d_stall_cnt", e.step), stall_count, e.sc);
         checkOutput($sformatf("s%0d_flush_cnt", e.step), flush_count, e.fc);
      end
   end

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_fwd_a"}, {30'd0, forward_a}, 32'd0);
      checkOutput({tag, "_fwd_b"}, {30'd0, forward_b}, 32'd0);
      checkOutput({tag, "_stall"}, {31'd0, stall}, 32'd0);
      checkOutput({tag, "_stall_cnt"}, stall_count, 32'd0);
      checkOutput({tag, "_flush_cnt"}, flush_count, 32'd0);
   endtask

   initial begin
      checkCount   = 0;
      errorCount   = 0;
      stepNum      = 0;
      expStallCnt  = '0;
      expFlushCnt  = '0;
      reset        = 1'b1;
      id_valid     = 1'b0;
      id_rs1       = '0;
      id_rs2       = '0;
      id_rd        = '0;
      id_reg_write = 1'b0;
      id_mem_read  = 1'b0;
      flush        = 1'b0;
      #1;
      checkResetState("reset_hold");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // EX-to-EX: add x5,x1,x2 ; sub x6,x5,x3
      applyStimulus(1, 5'd1,  5'd2,  5'd5,  1, 0, 0, 2'b00, 2'b00, 0);
      applyStimulus(1, 5'd5,  5'd3,  5'd6,  1, 0, 0, 2'b00, 2'b00, 0);
      applyStimulus(0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 2'b10, 2'b00, 0);

      // WB forward after one unrelated instruction, then MEM beats WB for double producers
      applyStimulus(1, 5'd3,  5'd4,  5'd7,  1, 0, 0, 2'b00, 2'b00, 0);
      applyStimulus(1, 5'd1,  5'd2,  5'd8,  1, 0, 0, 2'b00, 2'b00, 0);
      applyStimulus(1, 5'd11, 5'd7,  5'd12, 1, 0, 0, 2'b00, 2'b00, 0);
      applyStimulus(1, 5'd3,  5'd4,  5'd7,  1, 0, 0, 2'b00, 2'b01, 0);
      applyStimulus(1, 5'd5,  5'd6,  5'd7,  1, 0, 0, 2'b00, 2'b00, 0);
      applyStimulus(1, 5'd13, 5'd7,  5'd14, 1, 0, 0, 2'b00, 2'b00, 0);
      applyStimulus(0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 2'b00, 2'b10, 0);

      // Load-use: ld x9 ; add x10,x9,x4 (held one cycle by the stall)
      applyStimulus(1, 5'd2,  5'd0,  5'd9,  1, 1, 0, 2'b00, 2'b00, 0);
      applyStimulus(1, 5'd9,  5'd4,  5'd10, 1, 0, 0, 2'b00, 2'b00, 1);
      applyStimulus(1, 5'd9,  5'd4,  5'd10, 1, 0, 0, 2'b00, 2'b00, 0);
      applyStimulus(0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 2'b01, 2'b00, 0);

      // x0 is never forwarded; invalid ID slots never stall even with matching indices
      applyStimulus(1, 5'd1,  5'd2,  5'd0,  1, 0, 0, 2'b00, 2'b00, 0);
      applyStimulus(1, 5'd0,  5'd3,  5'd15, 1, 0, 0, 2'b00, 2'b00, 0);
      applyStimulus(1, 5'd1,  5'd2,  5'd16, 1, 1, 0, 2'b00, 2'b00, 0);
      applyStimulus(0, 5'd16, 5'd16, 5'd0,  0, 0, 0, 2'b00, 2'b00, 0);
      applyStimulus(0, 5'd16, 5'd16, 5'd0,  0, 0, 0, 2'b00, 2'b00, 0);

      // Flush wins over a load-use condition
      applyStimulus(1, 5'd1,  5'd2,  5'd17, 1, 1, 0, 2'b00, 2'b00, 0);
      applyStimulus(1, 5'd17, 5'd3,  5'd18, 1, 0, 1, 2'b00, 2'b00, 0);
      applyStimulus(0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 2'b00, 2'b00, 0);

      // Load and consumer in flight, then reset mid-cycle
      applyStimulus(1, 5'd1,  5'd2,  5'd20, 1, 1, 0, 2'b00, 2'b00, 0);
      applyStimulus(1, 5'd20, 5'd20, 5'd21, 1, 0, 0, 2'b00, 2'b00, 1);
      applyStimulus(1, 5'd20, 5'd20, 5'd21, 1, 0, 0, 2'b00, 2'b00, 0);
      applyStimulus(1, 5'd20, 5'd20, 5'd22, 1, 1, 0, 2'b01, 2'b01, 0);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkResetState("reset_mid");
      expStallCnt = '0;
      expFlushCnt = '0;
      @(posedge clk);
      #1;
      id_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // No stale forwarding after release
      applyStimulus(1, 5'd20, 5'd20, 5'd23, 1, 0, 0, 2'b00, 2'b00, 0);
      applyStimulus(0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 2'b00, 2'b00, 0);

      @(negedge clk);
      #1;
      checkOutput("scoreboard_drain", expQueue.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
